mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter word_size, default 16: data and address width in bits.
REQ-002 SHALL have parameter memory_size, default 16: number of valid memory words; legal addresses are 0..memory_size-1.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port A_REQ  input  1  port A (instruction fetch, read-only) request.
REQ-006 SHALL have port A_ADDR  input  word_size  port A read address.
REQ-007 SHALL have port A_GNT  output  1  port A request accepted (1-cycle pulse).
REQ-008 SHALL have port A_VALID  output  1  port A response (1-cycle pulse).
REQ-009 SHALL have port B_REQ  input  1  port B (load/store) request.
REQ-010 SHALL have port B_WE  input  1  port B write enable: 1 = store, 0 = load.
REQ-011 SHALL have port B_ADDR  input  word_size  port B address.
REQ-012 SHALL have port B_WDATA  input  word_size  port B store data.
REQ-013 SHALL have port B_GNT  output  1  port B request accepted (1-cycle pulse).
REQ-014 SHALL have port B_VALID  output  1  port B response (1-cycle pulse; also pulsed for stores).
REQ-015 SHALL have port RDATA  output  word_size  read data for the port whose VALID is high.
REQ-016 SHALL have port ERR  output  1  response error flag, qualified by A_VALID or B_VALID.
REQ-017 SHALL have memory-side ports MEM_ON, MEM_W (output 1 each), MEM_ADDR, MEM_DIN (output word_size each), MEM_DOUT (input word_size), driving the ON, W, ADDR, DATA_IN and DATA_OUT pins of the shared word memory.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-019 IDLE: if A_REQ or B_REQ is sampled high at a rising edge, SHALL latch the winner's address, write enable (0 for port A) and write data, then enter ACCESS; otherwise SHALL remain in IDLE.
REQ-020 ACCESS: SHALL assert the winner's GNT, drive MEM_ON=1, MEM_W=latched WE, and MEM_ADDR/MEM_DIN from the latch; on the next edge SHALL capture MEM_DOUT into RDATA for reads and enter RESP.
REQ-021 RESP: SHALL pulse the winner's VALID with RDATA/ERR valid; on the next edge SHALL arbitrate as in IDLE and go to ACCESS if any REQ is high, else to IDLE.
REQ-022 Latency SHALL be REQ sampled at edge k, GNT during cycle k+1, VALID during cycle k+2; peak throughput SHALL be one access per 2 cycles.
REQ-023 REQ/WE/ADDR/WDATA SHALL be ignored in ACCESS; a requester deasserts REQ in the cycle after GNT unless it is issuing a new request.
REQ-024 Outside ACCESS, MEM_ON, MEM_W, MEM_ADDR and MEM_DIN SHALL be 0.
REQ-025 An address >= memory_size SHALL keep MEM_ON=0 in ACCESS (no memory write) and SHALL respond with ERR=1 and RDATA=0.
REQ-026 RDATA SHALL hold its value until the next read response; a store response SHALL leave RDATA unchanged, with ERR=0 when in range.
REQ-027 Arbitration on simultaneous A_REQ and B_REQ SHALL follow REQ-031/REQ-032; a single requester SHALL always win.

Reset
REQ-028 RST_N low SHALL immediately force state IDLE, all GNT/VALID/ERR/MEM_* outputs to 0, RDATA to 0, and the round-robin pointer to "last = B".
REQ-029 Reset asserted during ACCESS SHALL drop MEM_ON combinationally, so no write commits; a pending response SHALL be discarded.

Configuration
REQ-030 SHALL provide macro MEM_ARB_RR_EN.
REQ-031 With MEM_ARB_RR_EN defined, SHALL arbitrate round-robin: on a tie, grant the port not granted last, updating the pointer on each grant.
REQ-032 Without MEM_ARB_RR_EN, SHALL use fixed priority, with port B always winning a tie and no pointer state.

Verification
REQ-033 Store then read: B_REQ, WE=1, ADDR=3, WDATA=16'hBEEF; then A_REQ, ADDR=3 -> B_VALID, ERR=0; A_VALID with RDATA=16'hBEEF.
REQ-034 Tie with MEM_ARB_RR_EN: A_REQ and B_REQ held high from reset -> grants A, B, A, B in ACCESS cycles 1, 3, 5, 7; without the macro -> B every grant.
REQ-035 Out of range: B write to ADDR=16 -> MEM_ON stays 0, B_VALID with ERR=1, RDATA=0; memory word 0 is unchanged.
REQ-036 Latency: A_REQ sampled at edge 10 -> A_GNT in cycle 11, A_VALID in cycle 12; back-to-back request -> next A_GNT in cycle 13.
REQ-037 Reset mid-write: RST_N low during an ACCESS write to ADDR=5 -> MEM_ON is 0 at once, word 5 keeps its old value, and all outputs are 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-port arbiter in front of a single shared word memory.
//   Port A is a read-only instruction-fetch port; port B issues loads and stores.
//   Each access is a three-phase sequence IDLE/RESP -> ACCESS -> RESP:
//   - the request is sampled at edge k;
//   - GNT is high during cycle k+1 while the memory is driven;
//   - VALID is high during cycle k+2.
//   Peak throughput is one access every two cycles.
//
//   Optional feature:
//     MEM_ARB_RR_EN  defined   -> round-robin tie break (the port not granted
//                                 last wins a tie)
//                    undefined -> fixed priority (port B wins every tie)
//
// Parameters
//   word_size    data and address width in bits
//   memory_size  number of valid words; addresses >= memory_size give ERR
//
// Ports
//   CLK, RST_N                    clock, asynchronous active-low reset
//   A_REQ, A_ADDR                 port A read request
//   A_GNT, A_VALID                port A accept / response pulses
//   B_REQ, B_WE, B_ADDR, B_WDATA  port B load/store request
//   B_GNT, B_VALID                port B accept / response pulses
//   RDATA, ERR                    response data and error, qualified by *_VALID
//   MEM_ON, MEM_W, MEM_ADDR,
//   MEM_DIN, MEM_DOUT             shared memory pins (read data is combinational)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int word_size   = 16,
  parameter int memory_size = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 A_REQ,
  input  logic [word_size-1:0] A_ADDR,
  output logic                 A_GNT,
  output logic                 A_VALID,
  input  logic                 B_REQ,
  input  logic                 B_WE,
  input  logic [word_size-1:0] B_ADDR,
  input  logic [word_size-1:0] B_WDATA,
  output logic                 B_GNT,
  output logic                 B_VALID,
  output logic [word_size-1:0] RDATA,
  output logic                 ERR,
  output logic                 MEM_ON,
  output logic                 MEM_W,
  output logic [word_size-1:0] MEM_ADDR,
  output logic [word_size-1:0] MEM_DIN,
  input  logic [word_size-1:0] MEM_DOUT
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  // One extra bit so that memory_size == 2**word_size is still representable.
  localparam logic [word_size:0] ADDR_LIMIT = (word_size + 1)'(memory_size);

  state_e               state_q, state_d;
  logic [word_size-1:0] addr_q, addr_d;
  logic [word_size-1:0] wdata_q, wdata_d;
  logic [word_size-1:0] rdata_q, rdata_d;
  logic                 we_q, we_d;
  logic                 win_b_q, win_b_d;
  logic                 err_q, err_d;

  logic arb_go;      // a request is being accepted at this edge
  logic pick_b;      // port B wins the current arbitration
  logic tie_pick_b;  // who wins when both ports request
  logic in_range;

  assign arb_go   = (state_q != ACCESS) && (A_REQ || B_REQ);
  assign pick_b   = B_REQ && (!A_REQ || tie_pick_b);
  assign in_range = {1'b0, addr_q} < ADDR_LIMIT;

`ifdef MEM_ARB_RR_EN
  logic last_b_q, last_b_d;

  assign tie_pick_b = ~last_b_q;
  assign last_b_d   = arb_go ? pick_b : last_b_q;

  // After reset the pointer says "B was last", so port A wins the first tie.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) last_b_q <= 1'b1;
    else        last_b_q <= last_b_d;
  end
`else
  assign tie_pick_b = 1'b1;
`endif

  // Next-state logic. IDLE and RESP arbitrate identically, so they share the
  // default branch.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    win_b_d = win_b_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ACCESS: begin
        state_d = RESP;
        err_d   = ~in_range;
        if (!in_range)  rdata_d = '0;
        else if (!we_q) rdata_d = MEM_DOUT;  // stores leave RDATA unchanged
      end
      default: begin
        if (arb_go) begin
          state_d = ACCESS;
          win_b_d = pick_b;
          addr_d  = pick_b ? B_ADDR : A_ADDR;
          we_d    = pick_b && B_WE;
          wdata_d = pick_b ? B_WDATA : '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      win_b_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      win_b_q <= win_b_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from the registered state only.
  // MEM_ON is also gated by RST_N, so a reset during ACCESS cannot commit a
  // write even before the state flop is seen to clear.
  always_comb begin
    A_GNT    = 1'b0;
    B_GNT    = 1'b0;
    A_VALID  = 1'b0;
    B_VALID  = 1'b0;
    ERR      = 1'b0;
    MEM_ON   = 1'b0;
    MEM_W    = 1'b0;
    MEM_ADDR = '0;
    MEM_DIN  = '0;
    if (state_q == ACCESS) begin
      A_GNT    = ~win_b_q;
      B_GNT    = win_b_q;
      MEM_ON   = in_range && RST_N;
      MEM_W    = we_q;
      MEM_ADDR = addr_q;
      MEM_DIN  = wdata_q;
    end
    if (state_q == RESP) begin
      A_VALID = ~win_b_q;
      B_VALID = win_b_q;
      ERR     = err_q;
    end
  end

  assign RDATA = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter, which it drives with randomized
//   requests on both ports.
//
//   Reference model (transaction level):
//   - arbitration opens at any edge at least two edges after the previous grant;
//   - ties resolve by round-robin or by B-priority, depending on MEM_ARB_RR_EN;
//   - a plain array holds the memory contents.
//
//   Scoreboard: expected grants and responses go into queues, and a separate
//   monitor compares them against what the DUT presents.
//
//   Directed cases:
//   - store-then-read;
//   - out-of-range store;
//   - reset in the middle of a write;
//   - sustained ties.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int W     = 16;
  localparam int MSIZE = 16;
  localparam int AW    = $clog2(MSIZE);

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         A_REQ, B_REQ, B_WE;
  logic [W-1:0] A_ADDR, B_ADDR, B_WDATA;
  logic         A_GNT, A_VALID, B_GNT, B_VALID, ERR;
  logic [W-1:0] RDATA;
  logic         MEM_ON, MEM_W;
  logic [W-1:0] MEM_ADDR, MEM_DIN, MEM_DOUT;

  mem_arbiter #(.word_size(W), .memory_size(MSIZE)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_GNT(A_GNT), .A_VALID(A_VALID),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_GNT(B_GNT), .B_VALID(B_VALID), .RDATA(RDATA), .ERR(ERR),
    .MEM_ON(MEM_ON), .MEM_W(MEM_W), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
    .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  // Memory attached to the DUT: combinational read, synchronous write.
  logic [W-1:0] mem     [MSIZE];
  logic [W-1:0] ref_mem [MSIZE];

  always @(posedge CLK)
    if (MEM_ON && MEM_W && 32'(MEM_ADDR) < MSIZE) mem[MEM_ADDR[AW-1:0]] <= MEM_DIN;

  assign MEM_DOUT = (32'(MEM_ADDR) < MSIZE) ? mem[MEM_ADDR[AW-1:0]] : '0;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit           is_b;
    bit           we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    int           cyc;    // cycle in which GNT is expected
    bit           err;
    logic [W-1:0] rdata;
  } txn_t;

  txn_t gq[$];
  txn_t rq[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit           pa, pb;          // pending request per port
  logic [W-1:0] pa_addr, pb_addr, pb_wdata;
  bit           pb_we;
  int           next_arb = 0;    // earliest edge at which a grant may happen
  bit           last_b   = 1'b1;
  logic [W-1:0] exp_rdata = '0;
  bit           mon_en    = 1'b0;

  function automatic logic [W-1:0] rand_addr();
    return W'($urandom_range(0, MSIZE + 3));
  endfunction

  // One cycle of stimulus. It possibly creates new requests, drives the pins,
  // and predicts the arbitration at the coming edge.
  task automatic step(input int prob);
    int   e;
    bit   wb;
    txn_t t;
    @(negedge CLK);
    if (!pa && $urandom_range(0, 99) < prob) begin
      pa      = 1'b1;
      pa_addr = rand_addr();
    end
    if (!pb && $urandom_range(0, 99) < prob) begin
      pb       = 1'b1;
      pb_we    = 1'($urandom_range(0, 1));
      pb_addr  = rand_addr();
      pb_wdata = W'($urandom);
    end
    A_REQ   = pa;
    A_ADDR  = pa_addr;
    B_REQ   = pb;
    B_WE    = pb_we;
    B_ADDR  = pb_addr;
    B_WDATA = pb_wdata;
    e = cyc + 1;
    if (e >= next_arb && (pa || pb)) begin
`ifdef MEM_ARB_RR_EN
      wb = pb && (!pa || !last_b);
`else
      wb = pb;
`endif
      last_b  = wb;
      t.is_b  = wb;
      t.we    = wb && pb_we;
      t.addr  = wb ? pb_addr : pa_addr;
      t.wdata = wb ? pb_wdata : '0;
      t.cyc   = e;
      if (32'(t.addr) >= MSIZE) begin
        t.err     = 1'b1;
        exp_rdata = '0;
      end else begin
        t.err = 1'b0;
        if (t.we) ref_mem[t.addr[AW-1:0]] = t.wdata;
        else      exp_rdata = ref_mem[t.addr[AW-1:0]];
      end
      t.rdata = exp_rdata;
      gq.push_back(t);
      rq.push_back(t);
      if (wb) pb = 1'b0;
      else    pa = 1'b0;
      next_arb = e + 2;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pa || pb || gq.size() != 0 || rq.size() != 0) && n < 60) begin
      step(0);
      n++;
    end
    check("drain_outstanding", 64'(gq.size() + rq.size() + int'(pa) + int'(pb)), 64'd0);
  endtask

  // Monitor: compares grants, memory pins and responses with the queues.
  always @(negedge CLK) begin : monitor
    txn_t t;
    if (RST_N && mon_en) begin
      if (A_GNT || B_GNT) begin
        if (gq.size() == 0) begin
          check("gnt_unexpected", {A_GNT, B_GNT}, 2'b00);
        end else begin
          t = gq.pop_front();
          check("gnt_port", {A_GNT, B_GNT}, t.is_b ? 2'b01 : 2'b10);
          check("gnt_cycle", cyc, t.cyc);
          check("mem_on", MEM_ON, 32'(t.addr) < MSIZE);
          check("mem_w", MEM_W, t.we);
          check("mem_addr", MEM_ADDR, t.addr);
          if (t.we) check("mem_din", MEM_DIN, t.wdata);
        end
      end else begin
        check("mem_idle", {MEM_ON, MEM_W, MEM_ADDR, MEM_DIN}, '0);
      end
      if (A_VALID || B_VALID) begin
        if (rq.size() == 0) begin
          check("valid_unexpected", {A_VALID, B_VALID}, 2'b00);
        end else begin
          t = rq.pop_front();
          check("valid_port", {A_VALID, B_VALID}, t.is_b ? 2'b01 : 2'b10);
          check("valid_cycle", cyc, t.cyc + 1);
          check("rsp_err", ERR, t.err);
          check("rsp_rdata", RDATA, t.rdata);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [W-1:0] old;
    logic [W-1:0] v;
    for (int i = 0; i < MSIZE; i++) begin
      v          = W'($urandom);
      mem[i]    <= v;
      ref_mem[i] = v;
    end
    A_REQ = 0; A_ADDR = '0; B_REQ = 0; B_WE = 0; B_ADDR = '0; B_WDATA = '0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #1;
    check("reset_outputs",
          {A_GNT, B_GNT, A_VALID, B_VALID, ERR, MEM_ON, MEM_W, RDATA, MEM_ADDR, MEM_DIN}, '0);
    repeat (2) @(negedge CLK);
    RST_N  = 1'b1;
    #1;
    check("post_reset_outputs",
          {A_GNT, B_GNT, A_VALID, B_VALID, ERR, MEM_ON, MEM_W, RDATA}, '0);
    mon_en = 1'b1;

    // Store then read back through the other port.
    pb = 1'b1; pb_we = 1'b1; pb_addr = 16'd3; pb_wdata = 16'hBEEF;
    drain();
    pa = 1'b1; pa_addr = 16'd3;
    drain();
    check("store_word3", mem[3], 16'hBEEF);

    // Out-of-range store must not touch memory.
    old = mem[0];
    pb = 1'b1; pb_we = 1'b1; pb_addr = 16'd16; pb_wdata = 16'h5A5A;
    drain();
    check("oor_word0", mem[0], old);

    // Randomized traffic, then sustained ties on both ports.
    repeat (600) step(40);
    repeat (40) step(100);
    drain();

    // Reset in the middle of a write to word 5.
    mon_en = 1'b0;
    old    = mem[5];
    @(negedge CLK);
    B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 16'd5; B_WDATA = ~old; A_REQ = 1'b0;
    @(posedge CLK);
    #2;
    check("rst_pre_access", {B_GNT, MEM_ON, MEM_W}, 3'b111);
    RST_N = 1'b0;
    #1;
    check("rst_mem_on", MEM_ON, 1'b0);
    check("rst_all_outputs",
          {A_GNT, B_GNT, A_VALID, B_VALID, ERR, MEM_W, RDATA, MEM_ADDR, MEM_DIN}, '0);
    B_REQ = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_word5", mem[5], old);
    @(negedge CLK);
    RST_N = 1'b1;
    ref_mem[5] = old;
    pa = 1'b0; pb = 1'b0;
    gq.delete(); rq.delete();
    next_arb = 0; last_b = 1'b1; exp_rdata = '0;
    mon_en = 1'b1;

    // Ties held from reset: A,B,A,B with round-robin, otherwise B always.
    repeat (10) step(100);
    drain();
    repeat (200) step(50);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
